// File: rtl/d0_rd_port.sv
// Sampling buffer for the D0 data register: rd_stb captures d_in into a
// small power-of-two FIFO that a downstream consumer drains with valid/ready.
module d0_rd_port #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rd_stb,
  input  logic [WIDTH-1:0]           d_in,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       ovf,
  input  logic                       ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    head_r;
  logic [AW-1:0]    tail_r;
  logic [LW-1:0]    level_r;
  logic             ovf_r;

  logic             full_s;
  logic             pop_s;
  logic             push_s;
  logic             overflow_s;
  logic [LW-1:0]    level_nxt_s;

  // Push/pop qualification; a pop frees the slot a full-buffer push needs.
  always_comb begin
    full_s     = (level_r == LW'(DEPTH));
    pop_s      = (level_r != {LW{1'b0}}) && out_ready;
    push_s     = rd_stb && (!full_s || pop_s);
    overflow_s = rd_stb && full_s && !pop_s;
  end

  // Occupancy next-state
  always_comb begin
    level_nxt_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + LW'(1);
      2'b01:   level_nxt_s = level_r - LW'(1);
      default: level_nxt_s = level_r;
    endcase
  end

  // Storage write; entries are cleared on reset so stale data never leaks out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (push_s) begin
      mem_r[tail_r] <= d_in;
    end
  end

  // Pointers, occupancy and sticky overflow (set has priority over clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r  <= {AW{1'b0}};
      tail_r  <= {AW{1'b0}};
      level_r <= {LW{1'b0}};
      ovf_r   <= 1'b0;
    end else begin
      if (push_s) begin
        tail_r <= tail_r + AW'(1);
      end
      if (pop_s) begin
        head_r <= head_r + AW'(1);
      end
      level_r <= level_nxt_s;
      if (overflow_s) begin
        ovf_r <= 1'b1;
      end else if (ovf_clr) begin
        ovf_r <= 1'b0;
      end
    end
  end

  // Outputs derive only from registered state, so reset clears them at once.
  always_comb begin
    out_valid = (level_r != {LW{1'b0}});
    level     = level_r;
    ovf       = ovf_r;
    if (out_valid) begin
      out_data = mem_r[head_r];
    end else begin
      out_data = {WIDTH{1'b0}};
    end
  end

endmodule

// File: tb/tb_d0_rd_port.sv
// Directed bench for d0_rd_port (WIDTH=8, DEPTH=4) with hand-computed expectations.
module tb_d0_rd_port;

  logic       clk;
  logic       rst_n;
  logic       rd_stb;
  logic [7:0] d_in;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] level;
  logic       ovf;
  logic       ovf_clr;

  int total;
  int bad;

  d0_rd_port #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_stb    (rd_stb),
    .d_in      (d_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [2:0] lv, input logic vl,
                         input logic [7:0] dt, input logic ov);
    chk({tag, ".level"}, 32'(level), 32'(lv));
    chk({tag, ".valid"}, 32'(out_valid), 32'(vl));
    chk({tag, ".data"}, 32'(out_data), 32'(dt));
    chk({tag, ".ovf"}, 32'(ovf), 32'(ov));
  endtask

  initial begin
    logic [7:0] drain_exp [4];
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    rd_stb = 1'b0;
    d_in = 8'h00;
    out_ready = 1'b0;
    ovf_clr = 1'b0;

    // Reset then idle
    #2;
    chk_all("reset", 3'd0, 1'b0, 8'h00, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    d_in = 8'h5C;
    step();
    chk_all("idle", 3'd0, 1'b0, 8'h00, 1'b0);

    // Single sample, no same-cycle bypass
    d_in = 8'hA5;
    rd_stb = 1'b1;
    #0;
    chk("single.nobypass", 32'(out_valid), 32'd0);
    step();
    rd_stb = 1'b0;
    d_in = 8'hFF;
    chk_all("single.push", 3'd1, 1'b1, 8'hA5, 1'b0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk_all("single.pop", 3'd0, 1'b0, 8'h00, 1'b0);

    // Fill and overflow
    rd_stb = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      d_in = 8'(n);
      step();
    end
    rd_stb = 1'b0;
    d_in = 8'hEE;
    chk_all("fill", 3'd4, 1'b1, 8'h01, 1'b1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk_all("ovf_clr", 3'd4, 1'b1, 8'h01, 1'b0);

    // Full with simultaneous push and pop
    rd_stb = 1'b1;
    d_in = 8'h10;
    out_ready = 1'b1;
    step();
    rd_stb = 1'b0;
    chk_all("fullpp", 3'd4, 1'b1, 8'h02, 1'b0);
    drain_exp[0] = 8'h02;
    drain_exp[1] = 8'h03;
    drain_exp[2] = 8'h04;
    drain_exp[3] = 8'h10;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d", i), 32'(out_data), 32'(drain_exp[i]));
      step();
    end
    chk_all("drained", 3'd0, 1'b0, 8'h00, 1'b0);

    // Wrap: continuous push and pop; first cycle is empty+pop+push
    rd_stb = 1'b1;
    for (int n = 0; n < 10; n++) begin
      d_in = 8'h20 + 8'(n);
      step();
      chk($sformatf("wrap%0d.data", n), 32'(out_data), 32'(8'h20 + 8'(n)));
      chk($sformatf("wrap%0d.level", n), 32'(level), 32'd1);
    end
    rd_stb = 1'b0;
    step();
    out_ready = 1'b0;
    chk_all("wrap.end", 3'd0, 1'b0, 8'h00, 1'b0);

    // Overflow coinciding with ovf_clr: set wins
    rd_stb = 1'b1;
    for (int n = 0; n < 4; n++) begin
      d_in = 8'h30 + 8'(n);
      step();
    end
    d_in = 8'h99;
    ovf_clr = 1'b1;
    step();
    rd_stb = 1'b0;
    chk_all("setwins", 3'd4, 1'b1, 8'h30, 1'b1);
    step();
    ovf_clr = 1'b0;
    chk("ovf_clr2", 32'(ovf), 32'd0);

    // Async reset mid-stream at level 3
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk_all("pre_rst", 3'd3, 1'b1, 8'h31, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 3'd0, 1'b0, 8'h00, 1'b0);
    #1;
    rst_n = 1'b1;
    d_in = 8'h7E;
    rd_stb = 1'b1;
    step();
    rd_stb = 1'b0;
    chk_all("post_rst", 3'd1, 1'b1, 8'h7E, 1'b0);

    // No push while reset held
    rst_n = 1'b0;
    rd_stb = 1'b1;
    d_in = 8'h55;
    step();
    chk_all("hold_rst", 3'd0, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
    rd_stb = 1'b0;
    step();
    chk_all("after_hold", 3'd0, 1'b0, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/d0_rd_port.md
D0_RD_PORT -- requirements
Module: d0_rd_port

Interface
REQ-001 Parameter WIDTH, default 8: data width of sampled register and output word.
REQ-002 Parameter DEPTH, default 4: buffer entries; SHALL be a power of two, >= 2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 rd_stb  input  1  sample request; when high at a rising edge, d_in is captured.
REQ-006 d_in  input  WIDTH  register value to sample (output of the D0 data register).
REQ-007 out_data  output  WIDTH  head-of-buffer word.
REQ-008 out_valid  output  1  high when buffer holds >= 1 word.
REQ-009 out_ready  input  1  consumer accepts head word when high with out_valid.
REQ-010 level  output  $clog2(DEPTH)+1  words currently buffered, 0..DEPTH.
REQ-011 ovf  output  1  sticky overflow flag.
REQ-012 ovf_clr  input  1  synchronous clear of ovf.

Function
REQ-013 Push: rd_stb=1 at edge and (level<DEPTH or pop in same cycle) -> d_in written at tail, tail pointer +1 modulo DEPTH.
REQ-014 Pop: out_valid=1 and out_ready=1 at edge -> head pointer +1 modulo DEPTH.
REQ-015 level SHALL update each edge as level + push - pop; never exceed DEPTH, never underflow.
REQ-016 out_valid SHALL equal (level != 0); out_ready while out_valid=0 SHALL have no effect.
REQ-017 out_data SHALL equal the entry at head pointer when out_valid=1, and WIDTH'h0 when level=0.
REQ-018 Latency: word pushed into empty buffer SHALL appear on out_data/out_valid the cycle after the capturing edge; no same-cycle bypass.
REQ-019 Order SHALL be strict FIFO; pointers wrap without loss of data or ordering.
REQ-020 Full + rd_stb + pop same edge: both occur, level stays DEPTH, ovf unchanged.
REQ-021 Full + rd_stb without pop: d_in dropped, buffer contents unchanged, ovf=1 from next cycle.
REQ-022 Empty + pop attempt + rd_stb same edge: push only, level 0->1.
REQ-023 ovf SHALL remain 1 until ovf_clr=1 at an edge; if ovf_clr and a new overflow coincide, ovf SHALL be 1 (set wins).
REQ-024 d_in SHALL be sampled only at edges where rd_stb=1; changes at other times SHALL not affect buffer contents.

Reset
REQ-025 rst_n=0 SHALL immediately, without clock, force level=0, out_valid=0, out_data=0, ovf=0, head=tail=0.
REQ-026 Buffer storage SHALL be cleared to 0 on reset.
REQ-027 Reset asserted mid-operation SHALL discard all buffered words; first edge after deassertion behaves as from empty.
REQ-028 No push or pop SHALL occur at any edge while rst_n=0.

Verification
REQ-029 Reset then idle: level=0, out_valid=0, out_data=8'h00, ovf=0 throughout.
REQ-030 Single sample: d_in=8'hA5, rd_stb one cycle, out_ready=0 -> next cycle out_valid=1, out_data=8'hA5, level=1; out_ready=1 one cycle -> level=0, out_data=8'h00.
REQ-031 Fill and overflow: push 8'h01..8'h05 back-to-back, out_ready=0 -> level=4, out_data=8'h01, 8'h05 dropped, ovf=1; ovf_clr one cycle -> ovf=0.
REQ-032 Full with simultaneous push/pop: buffer holds 01..04, rd_stb with d_in=8'h10 and out_ready=1 -> level=4, ovf=0, drain order 02,03,04,10.
REQ-033 Wrap: 10 cycles of continuous push (8'h20+n) and pop -> output sequence 8'h20..8'h29 in order, level<=1, ovf=0.
REQ-034 Async reset mid-stream: level=3, pulse rst_n low between edges -> outputs zero immediately; subsequent push of 8'h7E appears alone at level=1.
